axis_window_coeff_ctrl: RTL and testbench
=========================================

// Module: axis_window_coeff_ctrl
// PURPOSE
//  Double-buffered (ping-pong) coefficient store and bank scheduler for the AXI-Stream window block.
//  The window datapath reads the active bank through its mem_addr/mem_din port.
//  A configuration master writes new coefficients into the shadow bank.
//  A commit request swaps the banks only at a frame boundary, so no frame is ever windowed with mixed coefficients.
// PARAMETERS
//  window_length              32  valid coefficient addresses 0..window_length-1
//  window_coeff_width         16  coefficient word width (bits)
//  memory_depth_width          6  address width per bank; bank depth = 2**memory_depth_width
// PORTS
//  aclk           in   1    system clock; all logic on rising edge
//  resetn         in   1    synchronous reset, active low
//  cfg_wr_en      in   1    write strobe into shadow bank
//  cfg_wr_addr    in   MDW  write address (MDW = memory_depth_width)
//  cfg_wr_data    in   CW   write data (CW = window_coeff_width)
//  cfg_commit     in   1    request bank swap (single-cycle pulse)
//  cfg_busy       out  1    1 while a commit is pending; shadow bank is write-locked
//  cfg_err        out  1    sticky: a write was rejected; cleared only by reset
//  frame_active   in   1    window datapath is inside a frame (from first sample to tlast)
//  frame_done     in   1    pulse on the m_axis tlast handshake of the window block
//  win_mem_addr   in   MDW  datapath read address (window block mem_addr)
//  win_mem_dout   out  CW   datapath read data (window block mem_din)
//  active_bank    out  1    index of the bank currently read by the datapath
//  swap_count     out  16   number of completed swaps; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset (resetn=0 at a clock edge):
//   - state=LOAD, active_bank=0, cfg_busy=0, cfg_err=0, win_mem_dout=0, swap_count=0.
//   - RAM contents are not cleared.
//   - A pending commit is discarded.
//  Read path:
//   - win_mem_dout <= bank[active_bank][win_mem_addr] is registered; latency is 1 cycle.
//   - Reads are never stalled.
//  FSM, LOAD state:
//   - A write with cfg_wr_en=1 and cfg_wr_addr<window_length writes the shadow bank (~active_bank).
//   - A write with cfg_wr_addr>=window_length is dropped and sets cfg_err.
//   - cfg_commit=1 moves the FSM to PENDING and sets cfg_busy=1.
//   - A write and a commit in the same cycle: the write is performed first, then the FSM enters PENDING.
//  FSM, PENDING state:
//   - Every cfg_wr_en is dropped and sets cfg_err.
//   - A further cfg_commit is ignored.
//   - Swap condition: frame_done=1, or frame_active=0.
//   - On the edge where the swap condition holds: toggle active_bank, swap_count+1, cfg_busy=0, return to LOAD.
//  Swap timing:
//   - A read sampled on the swap edge still returns the old bank.
//   - From the next edge onward, reads return the new bank.
//   - frame_done and frame_active=1 in the same cycle: the swap occurs (frame_done wins).
//  After a swap:
//   - The new shadow bank holds the previous coefficients.
//   - The writer must reload every word it wants changed.
//  Commit latency:
//   - Idle datapath: 1 cycle from commit to active_bank toggle.
//   - Otherwise: the swap happens on the frame_done cycle.
// TESTING
//  T1: Reset, then read any win_mem_addr.
//      -> win_mem_dout=0, active_bank=0, cfg_busy=0, swap_count=0.
//  T2: frame_active=0; write addr 0..31 with data 16'd32767-i; pulse commit.
//      -> active_bank=1 on the next edge.
//      -> reading addr 5 gives 32762 one cycle later; swap_count=1.
//  T3: frame_active=1; commit.
//      -> cfg_busy stays 1 and active_bank is unchanged for 500 cycles.
//      -> frame_done pulse: swap on that edge, cfg_busy=0.
//  T4: Write addr 40 (window_length=32) in LOAD; write addr 3 during PENDING.
//      -> both dropped, cfg_err=1, bank contents unchanged.
//  T5: Write and commit in the same cycle, with frame_done in the following cycle.
//      -> the written word is present in the new active bank.
//  T6: resetn=0 while in PENDING.
//      -> state LOAD, active_bank=0, cfg_busy=0; later frame_done pulses cause no swap.

Source files
------------

// File: rtl/axis_window_coeff_ctrl_if.sv
// Configuration and datapath-read signals of the window coefficient controller.
// The master side is the configuration writer plus the window datapath. The slave side is the controller.
interface axis_window_coeff_ctrl_if #(
    parameter int memory_depth_width = 6,
    parameter int window_coeff_width = 16
);
    logic                          cfg_wr_en;
    logic [memory_depth_width-1:0] cfg_wr_addr;
    logic [window_coeff_width-1:0] cfg_wr_data;
    logic                          cfg_commit;
    logic                          cfg_busy;
    logic                          cfg_err;
    logic                          frame_active;
    logic                          frame_done;
    logic [memory_depth_width-1:0] win_mem_addr;
    logic [window_coeff_width-1:0] win_mem_dout;
    logic                          active_bank;
    logic [15:0]                   swap_count;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
        output frame_active, frame_done, win_mem_addr,
        input  cfg_busy, cfg_err, win_mem_dout, active_bank, swap_count
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, cfg_commit,
        input  frame_active, frame_done, win_mem_addr,
        output cfg_busy, cfg_err, win_mem_dout, active_bank, swap_count
    );
endinterface

// File: rtl/axis_window_coeff_ctrl.sv
// Ping-pong coefficient store for the window block. Writes land in the shadow bank.
// A commit swaps the banks only at a frame boundary, so a frame never sees mixed coefficients.
module axis_window_coeff_ctrl #(
    parameter int window_length      = 32,
    parameter int window_coeff_width = 16,
    parameter int memory_depth_width = 6
) (
    input logic                     aclk,
    input logic                     resetn,
    axis_window_coeff_ctrl_if.slave ctrl
);
    localparam int MDW = memory_depth_width;
    localparam int CW  = window_coeff_width;
    localparam logic [MDW:0] WIN_LEN = (MDW+1)'(window_length);

    typedef enum logic {
        ST_LOAD,
        ST_PENDING
    } state_t;

    state_t          state_q, state_d;
    logic            active_bank_q, active_bank_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [15:0]     swap_count_q, swap_count_d;
    logic [CW-1:0]   dout_q, dout_d;
    logic            mem_we;

    // Both banks share one array; the bank index is the address MSB.
    logic [CW-1:0]   coeff_mem [2**(MDW+1)];

    always_comb begin
        state_d       = state_q;
        active_bank_d = active_bank_q;
        busy_d        = busy_q;
        err_d         = err_q;
        swap_count_d  = swap_count_q;
        mem_we        = 1'b0;
        dout_d        = coeff_mem[{active_bank_q, ctrl.win_mem_addr}];

        unique case (state_q)
            ST_LOAD: begin
                if (ctrl.cfg_wr_en) begin
                    if ({1'b0, ctrl.cfg_wr_addr} < WIN_LEN) begin
                        mem_we = resetn;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (ctrl.cfg_commit) begin
                    state_d = ST_PENDING;
                    busy_d  = 1'b1;
                end
            end
            ST_PENDING: begin
                if (ctrl.cfg_wr_en) begin
                    err_d = 1'b1;
                end
                // frame_done wins over frame_active so the swap lands on the tlast beat.
                if (ctrl.frame_done || !ctrl.frame_active) begin
                    active_bank_d = ~active_bank_q;
                    swap_count_d  = swap_count_q + 16'd1;
                    busy_d        = 1'b0;
                    state_d       = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q       <= ST_LOAD;
            active_bank_q <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            swap_count_q  <= '0;
            dout_q        <= '0;
        end else begin
            state_q       <= state_d;
            active_bank_q <= active_bank_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            swap_count_q  <= swap_count_d;
            dout_q        <= dout_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            coeff_mem[{~active_bank_q, ctrl.cfg_wr_addr}] <= ctrl.cfg_wr_data;
        end
    end

    assign ctrl.cfg_busy     = busy_q;
    assign ctrl.cfg_err      = err_q;
    assign ctrl.win_mem_dout = dout_q;
    assign ctrl.active_bank  = active_bank_q;
    assign ctrl.swap_count   = swap_count_q;

endmodule

// File: tb/tb_axis_window_coeff_ctrl.sv
// Directed bench for axis_window_coeff_ctrl: reset, idle and in-frame swaps, write rejection,
// write+commit, and reset while a commit is pending.
module tb_axis_window_coeff_ctrl;
    logic aclk;
    logic resetn;
    int unsigned n_checks;
    int unsigned n_fail;

    axis_window_coeff_ctrl_if #(.memory_depth_width(6), .window_coeff_width(16)) bus ();

    axis_window_coeff_ctrl #(
        .window_length     (32),
        .window_coeff_width(16),
        .memory_depth_width(6)
    ) dut (
        .aclk  (aclk),
        .resetn(resetn),
        .ctrl  (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_word(input logic [5:0] addr, input logic [15:0] data);
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = addr;
        bus.cfg_wr_data = data;
        step();
        bus.cfg_wr_en   = 1'b0;
    endtask

    logic stable_ok;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn           = 1'b0;
        bus.cfg_wr_en    = 1'b0;
        bus.cfg_wr_addr  = '0;
        bus.cfg_wr_data  = '0;
        bus.cfg_commit   = 1'b0;
        bus.frame_active = 1'b0;
        bus.frame_done   = 1'b0;
        bus.win_mem_addr = 6'd9;

        // T1: reset values
        step();
        step();
        check_eq("t1_dout", 32'(bus.win_mem_dout), 32'd0);
        check_eq("t1_bank", 32'(bus.active_bank), 32'd0);
        check_eq("t1_busy", 32'(bus.cfg_busy), 32'd0);
        check_eq("t1_count", 32'(bus.swap_count), 32'd0);
        check_eq("t1_err", 32'(bus.cfg_err), 32'd0);
        resetn = 1'b1;
        step();

        // T2: idle-datapath load and swap into bank 1
        for (int i = 0; i < 32; i++) write_word(6'(i), 16'(32767 - i));
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        check_eq("t2_busy_set", 32'(bus.cfg_busy), 32'd1);
        check_eq("t2_bank_before", 32'(bus.active_bank), 32'd0);
        bus.win_mem_addr = 6'd5;
        step();
        check_eq("t2_bank_after", 32'(bus.active_bank), 32'd1);
        check_eq("t2_busy_clr", 32'(bus.cfg_busy), 32'd0);
        check_eq("t2_count", 32'(bus.swap_count), 32'd1);
        step();
        check_eq("t2_rd5", 32'(bus.win_mem_dout), 32'd32762);
        bus.win_mem_addr = 6'd31;
        step();
        check_eq("t2_rd31", 32'(bus.win_mem_dout), 32'd32736);

        // T3: commit inside a frame waits for frame_done
        bus.frame_active = 1'b1;
        for (int i = 0; i < 32; i++) write_word(6'(i), 16'h1000 + 16'(i));
        bus.win_mem_addr = 6'd5;
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        stable_ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step();
            if (bus.cfg_busy !== 1'b1 || bus.active_bank !== 1'b1 ||
                bus.win_mem_dout !== 16'd32762) stable_ok = 1'b0;
        end
        check_eq("t3_hold_500", 32'(stable_ok), 32'd1);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        check_eq("t3_bank", 32'(bus.active_bank), 32'd0);
        check_eq("t3_busy", 32'(bus.cfg_busy), 32'd0);
        check_eq("t3_count", 32'(bus.swap_count), 32'd2);
        check_eq("t3_swap_edge_old", 32'(bus.win_mem_dout), 32'd32762);
        step();
        check_eq("t3_new_bank_rd", 32'(bus.win_mem_dout), 32'h1005);

        // T4: out-of-range write and write during PENDING are dropped
        check_eq("t4_err_clear", 32'(bus.cfg_err), 32'd0);
        write_word(6'd3, 16'h0333);
        check_eq("t4_err_valid_wr", 32'(bus.cfg_err), 32'd0);
        write_word(6'd40, 16'hDEAD);
        check_eq("t4_err_oob", 32'(bus.cfg_err), 32'd1);
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        write_word(6'd4, 16'hBEEF);
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        check_eq("t4_still_pending", 32'(bus.cfg_busy), 32'd1);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        check_eq("t4_bank", 32'(bus.active_bank), 32'd1);
        check_eq("t4_count", 32'(bus.swap_count), 32'd3);
        bus.win_mem_addr = 6'd4;
        step();
        check_eq("t4_rd4_unchanged", 32'(bus.win_mem_dout), 32'd32763);
        bus.win_mem_addr = 6'd3;
        step();
        check_eq("t4_rd3_written", 32'(bus.win_mem_dout), 32'h0333);
        check_eq("t4_err_sticky", 32'(bus.cfg_err), 32'd1);

        // T5: write and commit in one cycle, frame_done next cycle
        bus.cfg_wr_en   = 1'b1;
        bus.cfg_wr_addr = 6'd7;
        bus.cfg_wr_data = 16'h7777;
        bus.cfg_commit  = 1'b1;
        step();
        bus.cfg_wr_en   = 1'b0;
        bus.cfg_commit  = 1'b0;
        check_eq("t5_busy", 32'(bus.cfg_busy), 32'd1);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        check_eq("t5_bank", 32'(bus.active_bank), 32'd0);
        bus.win_mem_addr = 6'd7;
        step();
        check_eq("t5_rd7", 32'(bus.win_mem_dout), 32'h7777);
        bus.win_mem_addr = 6'd8;
        step();
        check_eq("t5_rd8_kept", 32'(bus.win_mem_dout), 32'h1008);

        // T6: reset while PENDING with bank 1 active
        bus.frame_active = 1'b0;
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        step();
        check_eq("t6_pre_bank", 32'(bus.active_bank), 32'd1);
        check_eq("t6_pre_count", 32'(bus.swap_count), 32'd5);
        bus.frame_active = 1'b1;
        bus.cfg_commit = 1'b1;
        step();
        bus.cfg_commit = 1'b0;
        check_eq("t6_pending", 32'(bus.cfg_busy), 32'd1);
        resetn = 1'b0;
        step();
        check_eq("t6_rst_bank", 32'(bus.active_bank), 32'd0);
        check_eq("t6_rst_busy", 32'(bus.cfg_busy), 32'd0);
        check_eq("t6_rst_count", 32'(bus.swap_count), 32'd0);
        check_eq("t6_rst_err", 32'(bus.cfg_err), 32'd0);
        check_eq("t6_rst_dout", 32'(bus.win_mem_dout), 32'd0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.frame_done = 1'b1;
            step();
            bus.frame_done = 1'b0;
            step();
        end
        check_eq("t6_no_swap_bank", 32'(bus.active_bank), 32'd0);
        check_eq("t6_no_swap_count", 32'(bus.swap_count), 32'd0);
        bus.win_mem_addr = 6'd5;
        step();
        check_eq("t6_ram_kept", 32'(bus.win_mem_dout), 32'h1005);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
